// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: start bit, 5..8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Define UART_TX_FIFO_EN to add a 4-entry transmit FIFO in front of the shifter.
module uart_tx_param #(
  parameter int CLK_DIV   = 27,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  output logic       tx,
  output logic       tx_bsy,
  output logic       frame_done
);
  // state | meaning
  // IDLE  | line idle high, waiting for a byte
  // START | start bit (low)
  // DATA  | DATA_BITS data bits, LSB first
  // PAR   | parity bit (only when PARITY != 0)
  // STOP  | STOP_BITS stop bits (high)
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  localparam int BW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [7:0] DATA_MASK = 8'((1 << DATA_BITS) - 1);

  state_t          state, state_nx;
  logic [BW-1:0]   baud_cnt;
  logic [2:0]      bit_cnt;
  logic            stop_cnt;
  logic [7:0]      shreg, shreg_nx, load_byte, fifo_head;
  logic            par_bit, par_nx, tx_nx;
  logic            rdy_en, accept, byte_avail, load, fifo_empty;
  logic            baud_last, bit_last, stop_last;

  assign accept     = s_valid && s_ready;
  assign baud_last  = (baud_cnt == BW'(CLK_DIV - 1));
  assign bit_last   = (bit_cnt == 3'(DATA_BITS - 1));
  assign stop_last  = (stop_cnt == 1'(STOP_BITS - 1));
  assign frame_done = (state == STOP) && baud_last && stop_last;

`ifdef UART_TX_FIFO_EN
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] fifo_cnt;
  logic       push, pop;

  assign fifo_empty = (fifo_cnt == 3'd0);
  assign fifo_head  = fifo_mem[rd_ptr];
  assign s_ready    = rdy_en && (fifo_cnt != 3'd4);
  assign byte_avail = accept || !fifo_empty;
  // An empty FIFO is bypassed so the start bit still follows the accept edge directly.
  assign pop        = load && !fifo_empty;
  assign push       = accept && !(load && fifo_empty);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end
`else
  assign fifo_empty = 1'b1;
  assign fifo_head  = s_data;
  assign s_ready    = rdy_en && (state == IDLE);
  assign byte_avail = accept;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (byte_avail) state_nx = START;
      START: if (baud_last) state_nx = DATA;
      DATA:  if (baud_last && bit_last) state_nx = (PARITY != 0) ? PAR : STOP;
      PAR:   if (baud_last) state_nx = STOP;
      STOP:  if (frame_done) state_nx = byte_avail ? START : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign load      = (state_nx == START) && (state != START);
  assign load_byte = fifo_empty ? s_data : fifo_head;

  always_comb begin
    shreg_nx = shreg;
    par_nx   = par_bit;
    if (load) begin
      shreg_nx = load_byte;
      par_nx   = (PARITY == 1) ? ~^(load_byte & DATA_MASK) : ^(load_byte & DATA_MASK);
    end else if (state == DATA && baud_last) begin
      shreg_nx = {1'b0, shreg[7:1]};
    end
  end

  // tx is registered, so it is derived from where the FSM will be next cycle.
  always_comb begin
    tx_nx = 1'b1;
    case (state_nx)
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = shreg_nx[0];
      PAR:     tx_nx = par_nx;
      default: tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
      tx_bsy   <= 1'b0;
      rdy_en   <= 1'b0;
    end else begin
      state   <= state_nx;
      shreg   <= shreg_nx;
      par_bit <= par_nx;
      tx      <= tx_nx;
      tx_bsy  <= (state_nx != IDLE);
      rdy_en  <= 1'b1;
      if (state_nx != state || state == IDLE || baud_last) baud_cnt <= '0;
      else baud_cnt <= baud_cnt + BW'(1);
      if (state == DATA && baud_last) bit_cnt <= bit_last ? 3'd0 : bit_cnt + 3'd1;
      if (state_nx != state) stop_cnt <= 1'b0;
      else if (state == STOP && baud_last) stop_cnt <= stop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four CLK_DIV=4 instances (8N1, 8E1, 8O1, 7O2) checked bit-by-bit
// against a frame model built from the byte with plain arithmetic.
module tb_uart_tx_param;
  localparam int DIV = 4;
  localparam int DB [4] = '{8, 8, 8, 7};
  localparam int PR [4] = '{0, 2, 1, 1};
  localparam int ST [4] = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] s_valid_v = '0;
  logic [7:0] s_data_v [4];
  wire  [3:0] s_ready_v, tx_v, tx_bsy_v, fd_v;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid_v[0]), .s_ready(s_ready_v[0]), .s_data(s_data_v[0]),
    .tx(tx_v[0]), .tx_bsy(tx_bsy_v[0]), .frame_done(fd_v[0]));
  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid_v[1]), .s_ready(s_ready_v[1]), .s_data(s_data_v[1]),
    .tx(tx_v[1]), .tx_bsy(tx_bsy_v[1]), .frame_done(fd_v[1]));
  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid_v[2]), .s_ready(s_ready_v[2]), .s_data(s_data_v[2]),
    .tx(tx_v[2]), .tx_bsy(tx_bsy_v[2]), .frame_done(fd_v[2]));
  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_7o2 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid_v[3]), .s_ready(s_ready_v[3]), .s_data(s_data_v[3]),
    .tx(tx_v[3]), .tx_bsy(tx_bsy_v[3]), .frame_done(fd_v[3]));

  task automatic chk(input string tag, input logic obs, input logic exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  function automatic int frame_bits(int idx);
    return 1 + DB[idx] + ((PR[idx] != 0) ? 1 : 0) + ST[idx];
  endfunction

  // Bit k of the frame for byte b: start, data LSB first, parity, stops.
  function automatic logic exp_bit(int idx, logic [7:0] b, int k);
    int ones = 0;
    for (int i = 0; i < DB[idx]; i++) ones += int'(b[i]);
    if (k == 0) return 1'b0;
    if (k <= DB[idx]) return b[k-1];
    if (PR[idx] != 0 && k == DB[idx] + 1)
      return (PR[idx] == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
    return 1'b1;
  endfunction

  // Call just after the accept edge; returns at the negedge of the frame's last clock.
  task automatic check_frame(input int idx, input logic [7:0] b);
    int total = frame_bits(idx) * DIV;
    for (int n = 0; n < total; n++) begin
      @(negedge clk);
      chk($sformatf("tx[%0d] n=%0d", idx, n), tx_v[idx], exp_bit(idx, b, n / DIV));
      chk($sformatf("tx_bsy[%0d] n=%0d", idx, n), tx_bsy_v[idx], 1'b1);
      chk($sformatf("frame_done[%0d] n=%0d", idx, n), fd_v[idx], (n == total - 1));
`ifndef UART_TX_FIFO_EN
      chk($sformatf("s_ready_busy[%0d] n=%0d", idx, n), s_ready_v[idx], 1'b0);
`endif
    end
  endtask

  task automatic send(input int idx, input logic [7:0] b);
    @(negedge clk);
    s_data_v[idx]  = b;
    s_valid_v[idx] = 1'b1;
    chk($sformatf("s_ready_idle[%0d]", idx), s_ready_v[idx], 1'b1);
    @(posedge clk);
    #1;
    s_valid_v[idx] = 1'b0;
    s_data_v[idx]  = 8'($urandom);
    check_frame(idx, b);
    @(negedge clk);
    chk($sformatf("tx_after[%0d]", idx), tx_v[idx], 1'b1);
    chk($sformatf("tx_bsy_after[%0d]", idx), tx_bsy_v[idx], 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a, b2;
    logic [7:0] q [5];
    for (int i = 0; i < 4; i++) s_data_v[i] = 8'h00;

    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_tx[%0d]", i), tx_v[i], 1'b1);
      chk($sformatf("rst_tx_bsy[%0d]", i), tx_bsy_v[i], 1'b0);
      chk($sformatf("rst_frame_done[%0d]", i), fd_v[i], 1'b0);
      chk($sformatf("rst_s_ready[%0d]", i), s_ready_v[i], 1'b0);
    end
    rst_n = 1'b1;
    #1 chk("s_ready_before_edge", s_ready_v[0], 1'b0);
    @(negedge clk);
    chk("s_ready_after_edge", s_ready_v[0], 1'b1);

    send(0, 8'hA5);
    send(1, 8'h07);
    send(2, 8'h07);
    send(3, 8'h80);
    for (int i = 0; i < 4; i++)
      for (int r = 0; r < 4; r++) send(i, 8'($urandom));

`ifndef UART_TX_FIFO_EN
    // s_valid held across a frame: second byte must wait for one idle clock.
    a  = 8'($urandom);
    b2 = 8'($urandom);
    @(negedge clk);
    s_data_v[0]  = a;
    s_valid_v[0] = 1'b1;
    chk("hold_ready0", s_ready_v[0], 1'b1);
    @(posedge clk);
    #1 s_data_v[0] = b2;
    check_frame(0, a);
    @(negedge clk);
    chk("gap_tx", tx_v[0], 1'b1);
    chk("gap_tx_bsy", tx_bsy_v[0], 1'b0);
    chk("gap_s_ready", s_ready_v[0], 1'b1);
    @(posedge clk);
    #1 s_valid_v[0] = 1'b0;
    check_frame(0, b2);
    @(negedge clk);
    chk("gap_end_bsy", tx_bsy_v[0], 1'b0);
`else
    for (int i = 0; i < 5; i++) q[i] = 8'($urandom);
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          s_data_v[0]  = q[i];
          s_valid_v[0] = 1'b1;
          chk($sformatf("fifo_ready%0d", i), s_ready_v[0], 1'b1);
          @(posedge clk);
          @(negedge clk);
        end
        s_data_v[0] = 8'hFF;
        chk("fifo_full", s_ready_v[0], 1'b0);
        s_valid_v[0] = 1'b0;
      end
      begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) check_frame(0, q[i]);
      end
    join
    @(negedge clk);
    chk("fifo_end_bsy", tx_bsy_v[0], 1'b0);
    chk("fifo_end_tx", tx_v[0], 1'b1);
`endif

    // Reset in the middle of the data bits.
    @(negedge clk);
    s_data_v[0]  = 8'h00;
    s_valid_v[0] = 1'b1;
    @(posedge clk);
    #1 s_valid_v[0] = 1'b0;
    repeat (3 * DIV + 2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", tx_v[0], 1'b1);
    chk("mid_rst_tx_bsy", tx_bsy_v[0], 1'b0);
    chk("mid_rst_s_ready", s_ready_v[0], 1'b0);
    chk("mid_rst_frame_done", fd_v[0], 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_ready_early", s_ready_v[0], 1'b0);
    @(negedge clk);
    chk("post_rst_ready", s_ready_v[0], 1'b1);
    for (int n = 0; n < 12 * DIV; n++) begin
      @(negedge clk);
      chk($sformatf("post_rst_tx n=%0d", n), tx_v[0], 1'b1);
      chk($sformatf("post_rst_bsy n=%0d", n), tx_bsy_v[0], 1'b0);
    end
    send(3, 8'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
